// File: rtl/sdram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_burst_arbiter
//
// Shares one SDRAM controller command port between a write job source (frame
// capture) and a read job source (UDP frame sender). Each job covers a
// word-address range [begin, end). The range is cut into bursts of at most
// BURST_LEN words, and the two jobs are interleaved burst by burst in
// round-robin order. Each requester gets a one-cycle done pulse when its range
// is finished. A controller that never acknowledges a burst sets a sticky error,
// and the burst is issued again.
//
// Ports
//   clk, nRST                  clock; asynchronous active-low reset
//   wr_req/wr_begin/wr_end     write job start (rising edge) and range
//   wr_busy/wr_done            write job armed / one-cycle completion pulse
//   rd_req/rd_begin/rd_end     read job start (rising edge) and range
//   rd_busy/rd_done            read job armed / one-cycle completion pulse
//   cmd_valid/cmd_ready        burst command handshake to the controller
//   cmd_we/cmd_addr/cmd_len    burst direction, start address, length in words
//   cmd_ack                    one-cycle pulse: accepted burst finished
//   err                        sticky: ack timeout seen since reset
// -----------------------------------------------------------------------------
module sdram_burst_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_begin,
  input  logic [ADDR_W-1:0] wr_end,
  output logic              wr_busy,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_begin,
  input  logic [ADDR_W-1:0] rd_end,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              cmd_ack,
  output logic              err
);

  localparam int   TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic GNT_WR = 1'b1;
  localparam logic GNT_RD = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                wr_req_q, wr_req_d, wr_req_dly_q, wr_req_dly_d;
  logic                rd_req_q, rd_req_d, rd_req_dly_q, rd_req_dly_d;
  logic                wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic                wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_end_q, wr_end_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, rd_end_q, rd_end_d;
  logic                grant_q, grant_d, last_grant_q, last_grant_d;
  logic                cmd_valid_q, cmd_valid_d, cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [7:0]          cmd_len_q, cmd_len_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;

  logic                wr_elig, rd_elig, gnt;
  logic [ADDR_W-1:0]   nptr;

  // Remaining words compared one bit wider so end-ptr never wraps, then
  // saturated to BURST_LEN.
  function automatic logic [7:0] clamp_len(input logic [ADDR_W-1:0] ptr,
                                           input logic [ADDR_W-1:0] lim);
    logic [ADDR_W:0] rem;
    rem = {1'b0, lim} - {1'b0, ptr};
    if (rem > (ADDR_W+1)'(BURST_LEN)) clamp_len = 8'(BURST_LEN);
    else                              clamp_len = 8'(rem);
  endfunction

  assign wr_elig = wr_busy_q && (wr_ptr_q < wr_end_q);
  assign rd_elig = rd_busy_q && (rd_ptr_q < rd_end_q);

  always_comb begin
    state_d      = state_q;
    wr_req_d     = wr_req;
    wr_req_dly_d = wr_req_q;
    rd_req_d     = rd_req;
    rd_req_dly_d = rd_req_q;
    wr_busy_d    = wr_busy_q;
    rd_busy_d    = rd_busy_q;
    wr_done_d    = 1'b0;
    rd_done_d    = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    wr_end_d     = wr_end_q;
    rd_ptr_d     = rd_ptr_q;
    rd_end_d     = rd_end_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    timer_d      = timer_q;
    err_d        = err_q;
    gnt          = GNT_RD;
    nptr         = '0;

    // Arming on the registered request's rising edge. A busy job whose pointer
    // already sits at/after its end can only be a zero-length job (normal jobs
    // clear busy on their final ack), so it retires here without a command.
    if (wr_req_q && !wr_req_dly_q && !wr_busy_q) begin
      wr_busy_d = 1'b1;
      wr_ptr_d  = wr_begin;
      wr_end_d  = wr_end;
    end else if (wr_busy_q && !(wr_ptr_q < wr_end_q)) begin
      wr_busy_d = 1'b0;
      wr_done_d = 1'b1;
    end

    if (rd_req_q && !rd_req_dly_q && !rd_busy_q) begin
      rd_busy_d = 1'b1;
      rd_ptr_d  = rd_begin;
      rd_end_d  = rd_end;
    end else if (rd_busy_q && !(rd_ptr_q < rd_end_q)) begin
      rd_busy_d = 1'b0;
      rd_done_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_elig || rd_elig) begin
          // On a tie the requester that did not win last time goes next.
          gnt         = (wr_elig && rd_elig) ? ~last_grant_q : wr_elig;
          grant_d     = gnt;
          cmd_we_d    = gnt;
          cmd_addr_d  = (gnt == GNT_WR) ? wr_ptr_q : rd_ptr_q;
          cmd_len_d   = (gnt == GNT_WR) ? clamp_len(wr_ptr_q, wr_end_q)
                                        : clamp_len(rd_ptr_q, rd_end_q);
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d  = 1'b0;
          last_grant_d = grant_q;
          timer_d      = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cmd_ack) begin
          if (grant_q == GNT_WR) begin
            nptr     = wr_ptr_q + ADDR_W'(cmd_len_q);
            wr_ptr_d = nptr;
            if (nptr == wr_end_q) begin
              wr_busy_d = 1'b0;
              wr_done_d = 1'b1;
            end
          end else begin
            nptr     = rd_ptr_q + ADDR_W'(cmd_len_q);
            rd_ptr_d = nptr;
            if (nptr == rd_end_q) begin
              rd_busy_d = 1'b0;
              rd_done_d = 1'b1;
            end
          end
          state_d = S_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          // Pointer untouched: the same burst goes back through arbitration.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      wr_req_q     <= 1'b0;
      wr_req_dly_q <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_req_dly_q <= 1'b0;
      wr_busy_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_ptr_q     <= '0;
      wr_end_q     <= '0;
      rd_ptr_q     <= '0;
      rd_end_q     <= '0;
      grant_q      <= GNT_RD;
      last_grant_q <= GNT_RD;
      cmd_valid_q  <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_req_q     <= wr_req_d;
      wr_req_dly_q <= wr_req_dly_d;
      rd_req_q     <= rd_req_d;
      rd_req_dly_q <= rd_req_dly_d;
      wr_busy_q    <= wr_busy_d;
      rd_busy_q    <= rd_busy_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_end_q     <= wr_end_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_end_q     <= rd_end_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
    end
  end

  assign wr_busy   = wr_busy_q;
  assign wr_done   = wr_done_q;
  assign rd_busy   = rd_busy_q;
  assign rd_done   = rd_done_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_we    = cmd_we_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign err       = err_q;

endmodule
